multicycle_ctrl: RTL and testbench



---
 rtl/multicycle_ctrl_pkg.sv | 69 ++++++
 rtl/multicycle_ctrl_decode.sv | 31 +++
 rtl/multicycle_ctrl.sv | 156 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path.
package multicycle_ctrl_pkg;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned FN_W   = 6;
    localparam int unsigned ST_W   = 3;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned ALU_W  = 3;
    localparam int unsigned EOFF_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXE    = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

    localparam logic [FN_W-1:0] FN_ADDU  = 6'b100001;
    localparam logic [FN_W-1:0] FN_SUBU  = 6'b100011;
    localparam logic [FN_W-1:0] FN_JR    = 6'b001000;

    localparam logic [ALU_W-1:0] ALU_ADD   = 3'd0;
    localparam logic [ALU_W-1:0] ALU_SUB   = 3'd1;
    localparam logic [ALU_W-1:0] ALU_OR    = 3'd2;
    localparam logic [ALU_W-1:0] ALU_PASSB = 3'd3;

    localparam logic [SEL_W-1:0] NPC_PC4 = 2'd0;
    localparam logic [SEL_W-1:0] NPC_BR  = 2'd1;
    localparam logic [SEL_W-1:0] NPC_JMP = 2'd2;
    localparam logic [SEL_W-1:0] NPC_REG = 2'd3;

    localparam logic [SEL_W-1:0] WSEL_RD = 2'd0;
    localparam logic [SEL_W-1:0] WSEL_RT = 2'd1;
    localparam logic [SEL_W-1:0] WSEL_RA = 2'd2;

    localparam logic [SEL_W-1:0] WDSEL_ALU = 2'd0;
    localparam logic [SEL_W-1:0] WDSEL_DM  = 2'd1;
    localparam logic [SEL_W-1:0] WDSEL_PC  = 2'd2;

    localparam logic [EOFF_W-1:0] EOFFZ = 2'b00;
    localparam logic [EOFF_W-1:0] EOFFU = 2'b01;
    localparam logic [EOFF_W-1:0] EOFFS = 2'b10;

    // One-hot instruction class; nop covers every unsupported encoding.
    typedef struct packed {
        logic addu;
        logic subu;
        logic jr;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic nop;
    } iclass_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational op/funct decode into a one-hot instruction class.
module multicycle_ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    input  logic [FN_W-1:0] funct_i,
    output iclass_t         cls_o
);

    logic rtype;

    assign rtype = (op_i == OP_RTYPE);

    // Match each supported encoding; anything unmatched falls to nop.
    always_comb begin
        cls_o      = '0;
        cls_o.addu = rtype && (funct_i == FN_ADDU);
        cls_o.subu = rtype && (funct_i == FN_SUBU);
        cls_o.jr   = rtype && (funct_i == FN_JR);
        cls_o.ori  = (op_i == OP_ORI);
        cls_o.lui  = (op_i == OP_LUI);
        cls_o.lw   = (op_i == OP_LW);
        cls_o.sw   = (op_i == OP_SW);
        cls_o.beq  = (op_i == OP_BEQ);
        cls_o.j    = (op_i == OP_J);
        cls_o.jal  = (op_i == OP_JAL);
        cls_o.nop  = ~|{cls_o.addu, cls_o.subu, cls_o.jr, cls_o.ori, cls_o.lui,
                        cls_o.lw, cls_o.sw, cls_o.beq, cls_o.j, cls_o.jal};
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter bit MEM_HS = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [OP_W-1:0]   op_i,
    input  logic [FN_W-1:0]   funct_i,
    input  logic              zero_i,
    input  logic              mem_ready_i,
    output logic [ST_W-1:0]   state_o,
    output logic              pc_we_o,
    output logic [SEL_W-1:0]  npc_sel_o,
    output logic              ir_we_o,
    output logic              rf_we_o,
    output logic [SEL_W-1:0]  rf_wsel_o,
    output logic [SEL_W-1:0]  rf_wdsel_o,
    output logic              dm_we_o,
    output logic [ALU_W-1:0]  alu_op_o,
    output logic              alu_srcb_o,
    output logic [EOFF_W-1:0] eoff_sign_o
);

    state_e  state_q;
    state_e  state_d;
    iclass_t cls;
    logic    ready;

    assign ready   = MEM_HS ? mem_ready_i : 1'b1;
    assign state_o = ST_W'(state_q);

    multicycle_ctrl_decode u_decode (
        .op_i    (op_i),
        .funct_i (funct_i),
        .cls_o   (cls)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing; illegal codes recover to FETCH.
    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:  state_d = ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (cls.j || cls.jal || cls.jr || cls.nop) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXE;
                end
            end
            ST_EXE: begin
                if (cls.lw || cls.sw) begin
                    state_d = ST_MEM;
                end else if (cls.addu || cls.subu || cls.ori || cls.lui) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                if (!ready) begin
                    state_d = ST_MEM;
                end else if (cls.lw) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            default: state_d = ST_FETCH;
        endcase
    end

    // Datapath strobes and selects; everything is forced to 0 while in reset.
    always_comb begin
        pc_we_o     = 1'b0;
        npc_sel_o   = NPC_PC4;
        ir_we_o     = 1'b0;
        rf_we_o     = 1'b0;
        rf_wsel_o   = WSEL_RD;
        rf_wdsel_o  = WDSEL_ALU;
        dm_we_o     = 1'b0;
        alu_op_o    = ALU_ADD;
        alu_srcb_o  = 1'b0;
        eoff_sign_o = EOFFZ;
        if (rst_n_i) begin
            // ALU and extender configuration holds from DECODE through WB.
            if ((state_q == ST_DECODE) || (state_q == ST_EXE) ||
                (state_q == ST_MEM)    || (state_q == ST_WB)) begin
                if (cls.subu || cls.beq) begin
                    alu_op_o = ALU_SUB;
                end else if (cls.ori) begin
                    alu_op_o = ALU_OR;
                end else if (cls.lui) begin
                    alu_op_o = ALU_PASSB;
                end
                alu_srcb_o = cls.ori || cls.lui || cls.lw || cls.sw;
                if (cls.lui) begin
                    eoff_sign_o = EOFFU;
                end else if (cls.lw || cls.sw || cls.beq) begin
                    eoff_sign_o = EOFFS;
                end
            end
            case (state_q)
                ST_FETCH: begin
                    ir_we_o = ready;
                    pc_we_o = ready;
                end
                ST_DECODE: begin
                    if (cls.j || cls.jal) begin
                        pc_we_o   = 1'b1;
                        npc_sel_o = NPC_JMP;
                    end else if (cls.jr) begin
                        pc_we_o   = 1'b1;
                        npc_sel_o = NPC_REG;
                    end
                    if (cls.jal) begin
                        rf_we_o    = 1'b1;
                        rf_wsel_o  = WSEL_RA;
                        rf_wdsel_o = WDSEL_PC;
                    end
                end
                ST_EXE: begin
                    if (cls.beq) begin
                        pc_we_o   = zero_i;
                        npc_sel_o = NPC_BR;
                    end
                end
                ST_MEM: begin
                    dm_we_o = cls.sw;
                end
                ST_WB: begin
                    rf_we_o = 1'b1;
                    if (cls.ori || cls.lui || cls.lw) begin
                        rf_wsel_o = WSEL_RT;
                    end
                    if (cls.lw) begin
                        rf_wdsel_o = WDSEL_DM;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed vector bench for the multicycle control FSM.
module tb_multicycle_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic [5:0] op_i;
    logic [5:0] funct_i;
    logic       zero_i;
    logic       mem_ready_i;
    logic [2:0] state_o;
    logic       pc_we_o;
    logic [1:0] npc_sel_o;
    logic       ir_we_o;
    logic       rf_we_o;
    logic [1:0] rf_wsel_o;
    logic [1:0] rf_wdsel_o;
    logic       dm_we_o;
    logic [2:0] alu_op_o;
    logic       alu_srcb_o;
    logic [1:0] eoff_sign_o;

    int checks = 0;
    int errors = 0;

    localparam int ORI = 6'b001101;
    localparam int LUI = 6'b001111;
    localparam int LW  = 6'b100011;
    localparam int SW  = 6'b101011;
    localparam int BEQ = 6'b000100;
    localparam int J   = 6'b000010;
    localparam int JAL = 6'b000011;
    localparam int ADDU = 6'b100001;
    localparam int SUBU = 6'b100011;
    localparam int JR   = 6'b001000;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        zero;
        logic        rdy;
        logic [18:0] exp;
    } vec_t;

    vec_t tbl[$];
    vec_t tmp;

    multicycle_ctrl dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .op_i        (op_i),
        .funct_i     (funct_i),
        .zero_i      (zero_i),
        .mem_ready_i (mem_ready_i),
        .state_o     (state_o),
        .pc_we_o     (pc_we_o),
        .npc_sel_o   (npc_sel_o),
        .ir_we_o     (ir_we_o),
        .rf_we_o     (rf_we_o),
        .rf_wsel_o   (rf_wsel_o),
        .rf_wdsel_o  (rf_wdsel_o),
        .dm_we_o     (dm_we_o),
        .alu_op_o    (alu_op_o),
        .alu_srcb_o  (alu_srcb_o),
        .eoff_sign_o (eoff_sign_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected output word: {state, pc_we, npc, ir_we, rf_we, wsel, wdsel, dm_we, alu, srcb, eoff}
    function automatic vec_t v(input int op, input int fn, input int zero, input int rdy,
                               input int st, input int pcwe, input int npc, input int irwe,
                               input int rfwe, input int wsel, input int wdsel, input int dmwe,
                               input int alu, input int srcb, input int eoff);
        vec_t r;
        r.op   = 6'(op);
        r.fn   = 6'(fn);
        r.zero = 1'(zero);
        r.rdy  = 1'(rdy);
        r.exp  = {3'(st), 1'(pcwe), 2'(npc), 1'(irwe), 1'(rfwe), 2'(wsel), 2'(wdsel),
                  1'(dmwe), 3'(alu), 1'(srcb), 2'(eoff)};
        return r;
    endfunction

    function automatic vec_t vf(input int op, input int fn);
        return v(op, fn, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic [18:0] act();
        return {state_o, pc_we_o, npc_sel_o, ir_we_o, rf_we_o, rf_wsel_o, rf_wdsel_o,
                dm_we_o, alu_op_o, alu_srcb_o, eoff_sign_o};
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, a, e);
        end
    endtask

    int  lw_cyc;
    int  lw_pulses;
    int  lw_wdsel;
    int  lw_wsel;
    bit  lw_left;
    bit  lw_done;

    initial begin
        // FETCH stalled on memory
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // ori: OR, imm, zero-extend, WB to rt
        tbl.push_back(vf(ORI, 0));
        tbl.push_back(v(ORI, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0));
        tbl.push_back(v(ORI, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0));
        tbl.push_back(v(ORI, 0, 0, 1, 4, 0, 0, 0, 1, 1, 0, 0, 2, 1, 0));
        // lui: PASSB, Eoffu
        tbl.push_back(vf(LUI, 0));
        tbl.push_back(v(LUI, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3, 1, 1));
        tbl.push_back(v(LUI, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 3, 1, 1));
        tbl.push_back(v(LUI, 0, 0, 1, 4, 0, 0, 0, 1, 1, 0, 0, 3, 1, 1));
        // beq taken
        tbl.push_back(vf(BEQ, 0));
        tbl.push_back(v(BEQ, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2));
        tbl.push_back(v(BEQ, 0, 1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1, 0, 2));
        // beq not taken
        tbl.push_back(vf(BEQ, 0));
        tbl.push_back(v(BEQ, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2));
        tbl.push_back(v(BEQ, 0, 0, 1, 2, 0, 1, 0, 0, 0, 0, 0, 1, 0, 2));
        // sw with one MEM wait cycle
        tbl.push_back(vf(SW, 0));
        tbl.push_back(v(SW, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
        tbl.push_back(v(SW, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
        tbl.push_back(v(SW, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2));
        tbl.push_back(v(SW, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2));
        // jal
        tbl.push_back(vf(JAL, 0));
        tbl.push_back(v(JAL, 0, 0, 1, 1, 1, 2, 0, 1, 2, 2, 0, 0, 0, 0));
        // jr
        tbl.push_back(vf(0, JR));
        tbl.push_back(v(0, JR, 0, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        // nop
        tbl.push_back(vf(0, 0));
        tbl.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // addu
        tbl.push_back(vf(0, ADDU));
        tbl.push_back(v(0, ADDU, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, ADDU, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, ADDU, 0, 1, 4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        // subu
        tbl.push_back(vf(0, SUBU));
        tbl.push_back(v(0, SUBU, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, SUBU, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, SUBU, 0, 1, 4, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
        // j
        tbl.push_back(vf(J, 0));
        tbl.push_back(v(J, 0, 0, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        // unknown opcode behaves as nop
        tbl.push_back(vf(6'b111111, 0));
        tbl.push_back(v(6'b111111, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // lw without waits
        tbl.push_back(vf(LW, 0));
        tbl.push_back(v(LW, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
        tbl.push_back(v(LW, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
        tbl.push_back(v(LW, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
        tbl.push_back(v(LW, 0, 0, 1, 4, 0, 0, 0, 1, 1, 1, 0, 0, 1, 2));
        // trailing nop to land back in FETCH
        tbl.push_back(vf(0, 0));
        tbl.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        rst_n_i     = 1'b0;
        op_i        = '0;
        funct_i     = '0;
        zero_i      = 1'b0;
        mem_ready_i = 1'b1;
        #2;
        chk("reset_outputs", 32'(act()), 32'h0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;

        // Table-driven cycle-by-cycle sequence
        for (int i = 0; i < tbl.size(); i++) begin
            op_i        = tbl[i].op;
            funct_i     = tbl[i].fn;
            zero_i      = tbl[i].zero;
            mem_ready_i = tbl[i].rdy;
            @(negedge clk_i);
            chk($sformatf("vec%0d", i), 32'(act()), 32'(tbl[i].exp));
            @(posedge clk_i); #1;
        end

        // Reset asserted in MEM of a stalled sw
        op_i = 6'(SW); funct_i = '0; mem_ready_i = 1'b1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        mem_ready_i = 1'b0;
        @(negedge clk_i);
        chk("sw_mem_before_reset", 32'({state_o, dm_we_o}), 32'(4'b0111));
        #1 rst_n_i = 1'b0;
        mem_ready_i = 1'b1;
        #1;
        chk("rst_async_outputs", 32'(act()), 32'h0);
        op_i = '0;
        @(posedge clk_i); #1;
        chk("rst_held_outputs", 32'(act()), 32'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        tmp = vf(0, 0);
        chk("post_rst_fetch", 32'(act()), 32'(tmp.exp));
        @(posedge clk_i); #1;
        chk("post_rst_decode_state", 32'(state_o), 32'd1);
        @(posedge clk_i); #1;

        // lw with 2 FETCH waits and 3 MEM waits
        op_i = 6'(LW); funct_i = '0;
        lw_cyc = 0; lw_pulses = 0; lw_wdsel = -1; lw_wsel = -1;
        lw_left = 1'b0; lw_done = 1'b0;
        for (int c = 0; c < 30 && !lw_done; c++) begin
            mem_ready_i = !(c inside {0, 1, 5, 6, 7});
            @(negedge clk_i);
            if (state_o != 3'd0) begin
                lw_left = 1'b1;
            end else if (lw_left) begin
                lw_done = 1'b1;
            end
            if (!lw_done) begin
                lw_cyc++;
                if (rf_we_o) begin
                    lw_pulses++;
                    lw_wdsel = int'(rf_wdsel_o);
                    lw_wsel  = int'(rf_wsel_o);
                end
            end
            @(posedge clk_i); #1;
        end
        chk("lw_completed", 32'(lw_done), 32'd1);
        chk("lw_cycles", 32'(lw_cyc), 32'd10);
        chk("lw_rf_we_pulses", 32'(lw_pulses), 32'd1);
        chk("lw_wb_wdsel", 32'(lw_wdsel), 32'd1);
        chk("lw_wb_wsel", 32'(lw_wsel), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
